// File: rtl/tab_pkg.sv
// Shared definitions for the table sequencer.
// Holds the sequencer state type and the default widths for the
// state code (EA_W) and the tick divisor (DIV_W).
package tab_pkg;

    localparam int EA_W_DEFAULT  = 4;
    localparam int DIV_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } tab_state_t;

endpackage

// File: rtl/tab_prescaler.sv
// Tick prescaler for the table sequencer.
// Counts 0..div while enabled and raises tick on the terminal count,
// then wraps back to 0. With div = 0 a tick is produced every enabled cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous return of the count to 0 (wins over enable)
//   enable     : count advances only while high; otherwise frozen
//   div        : terminal count (tick period minus one)
//   tick       : high in the enabled cycle whose count equals div
module tab_prescaler #(
    parameter int DIV_W = tab_pkg::DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    assign tick = enable && (count == div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == div) begin
                count <= '0;
            end else begin
                count <= count + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/tab_sequenciador.sv
// Table sequencer: steps a state code ea from first to last (wrapping
// modulo 2^EA_W) at one step per prescaler tick, then pulses done.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : load first/last/div and (re)start sequencing
//   stop                : abort back to idle, ea keeps its value
//   hold                : level, freezes ea and the prescaler while high
//   first, last, div    : sequence bounds and tick period minus one,
//                         only looked at on an accepted start
//   ea                  : registered state code for the output decoder
//   busy                : registered, high while running or held
//   done                : registered, one-cycle pulse after ea reached last
//
// state | meaning
// IDLE  | waiting for start, ea keeps its last value
// RUN   | stepping ea on each prescaler tick
// HOLD  | frozen by hold; with hold low it behaves as RUN and returns there
// DONE  | one-cycle done pulse, then back to IDLE
module tab_sequenciador
    import tab_pkg::*;
#(
    parameter int EA_W  = tab_pkg::EA_W_DEFAULT,
    parameter int DIV_W = tab_pkg::DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic [EA_W-1:0]  first,
    input  logic [EA_W-1:0]  last,
    input  logic [DIV_W-1:0] div,
    output logic [EA_W-1:0]  ea,
    output logic             busy,
    output logic             done
);

    tab_state_t       state_q;
    tab_state_t       state_d;
    logic [EA_W-1:0]  ea_q;
    logic [EA_W-1:0]  ea_d;
    logic [EA_W-1:0]  last_q;
    logic [DIV_W-1:0] div_q;
    logic             busy_q;
    logic             done_q;
    logic             load;
    logic             cnt_en;
    logic             tick;

    // first only seeds ea on load, so it needs no register of its own.

    // The prescaler advances only in a cycle that is neither aborted,
    // restarted nor held; this also gives hold precedence over a tick.
    assign cnt_en = ((state_q == RUN) || (state_q == HOLD)) && !stop && !start && !hold;

    tab_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (load),
        .enable (cnt_en),
        .div    (div_q),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        ea_d    = ea_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!stop && start) begin
                    load    = 1'b1;
                    ea_d    = first;
                    state_d = RUN;
                end
            end
            RUN, HOLD: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    load    = 1'b1;
                    ea_d    = first;
                    state_d = RUN;
                end else if (hold) begin
                    state_d = HOLD;
                end else begin
                    state_d = RUN;
                    if (tick) begin
                        if (ea_q == last_q) begin
                            state_d = DONE;
                        end else begin
                            ea_d = ea_q + EA_W'(1);
                        end
                    end
                end
            end
            DONE: begin
                if (!stop && start) begin
                    load    = 1'b1;
                    ea_d    = first;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ea_q    <= '0;
            last_q  <= '0;
            div_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ea_q    <= ea_d;
            busy_q  <= (state_d == RUN) || (state_d == HOLD);
            done_q  <= (state_d == DONE);
            if (load) begin
                last_q <= last;
                div_q  <= div;
            end
        end
    end

    assign ea   = ea_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
